rv32i_regfile: RTL and testbench

RV32I_REGFILE -- requirements
Module: rv32i_regfile

---
 rtl/rv32i_regfile.sv | 123 ++++++++++++
 tb/tb_rv32i_regfile.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_regfile.sv
// RV32I integer register file (x1..x31, x0 hard-wired to zero) with program counter.
// After every reset a 31-cycle sweep clears the GPRs before writes are accepted.
module rv32i_regfile #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] reg_sel_rs1,
  input  logic [31:0] reg_sel_rs2,
  input  logic [31:0] reg_sel_rd,
  input  logic [31:0] reg_rd,
  input  logic        rd_we,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_in_vld,
  input  logic        pc_step,
  output logic [31:0] reg_rs1,
  output logic [31:0] reg_rs2,
  output logic [31:0] pc_out,
  output logic        rf_ready
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_r;
  logic [4:0]  sweep_r;
  logic [29:0] pc_word_r;
  logic        ready_r;
  logic [31:0] gpr_r [1:31];

  logic [4:0]  rs1_idx_s;
  logic [4:0]  rs2_idx_s;
  logic [4:0]  rd_idx_s;
  logic        wr_en_s;
  logic        unused_s;

  assign rs1_idx_s = reg_sel_rs1[4:0];
  assign rs2_idx_s = reg_sel_rs2[4:0];
  assign rd_idx_s  = reg_sel_rd[4:0];
  assign wr_en_s   = (state_r == RUN) && rd_we && (rd_idx_s != 5'd0);
  assign unused_s  = ^{reg_sel_rs1[31:5], reg_sel_rs2[31:5], reg_sel_rd[31:5],
                       pc_in[1:0], pc_in_vld[31:1]};

  // The PC is kept as a word address so its low two bits are zero by construction.
  assign pc_out   = {pc_word_r, 2'b00};
  assign rf_ready = ready_r;

  // Control state: init sweep sequencing, ready flag and PC update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= INIT;
      sweep_r   <= 5'd1;
      pc_word_r <= RESET_PC[31:2];
      ready_r   <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          if (sweep_r == 5'd31) begin
            state_r <= RUN;
            ready_r <= 1'b1;
          end else begin
            sweep_r <= sweep_r + 5'd1;
            ready_r <= 1'b0;
          end
        end
        RUN: begin
          ready_r <= 1'b1;
          if (pc_in_vld[0]) begin
            pc_word_r <= pc_in[31:2];
          end else if (pc_step) begin
            pc_word_r <= pc_word_r + 30'd1;
          end else begin
            pc_word_r <= pc_word_r;
          end
        end
        default: begin
          state_r <= INIT;
          sweep_r <= 5'd1;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // GPR array: cleared only by the sweep, never by rst itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == INIT) begin
        gpr_r[sweep_r] <= 32'h0000_0000;
      end else if (wr_en_s) begin
        gpr_r[rd_idx_s] <= reg_rd;
      end
    end
  end

  // rs1 read port with optional same-cycle forwarding of the writeback data.
  always_comb begin
    reg_rs1 = 32'h0000_0000;
    if ((state_r != RUN) || (rs1_idx_s == 5'd0)) begin
      reg_rs1 = 32'h0000_0000;
    end else if (BYPASS && wr_en_s && (rd_idx_s == rs1_idx_s)) begin
      reg_rs1 = reg_rd;
    end else begin
      reg_rs1 = gpr_r[rs1_idx_s];
    end
  end

  // rs2 read port, forwarded independently of rs1.
  always_comb begin
    reg_rs2 = 32'h0000_0000;
    if ((state_r != RUN) || (rs2_idx_s == 5'd0)) begin
      reg_rs2 = 32'h0000_0000;
    end else if (BYPASS && wr_en_s && (rd_idx_s == rs2_idx_s)) begin
      reg_rs2 = reg_rd;
    end else begin
      reg_rs2 = gpr_r[rs2_idx_s];
    end
  end

endmodule

// File: tb/tb_rv32i_regfile.sv
// Bench for rv32i_regfile: directed scenarios then random traffic, with a forwarding
// and a non-forwarding instance sharing stimulus, checked against an array model.
module tb_rv32i_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] reg_sel_rs1, reg_sel_rs2, reg_sel_rd, reg_rd;
  logic        rd_we;
  logic [31:0] pc_in, pc_in_vld;
  logic        pc_step;
  logic [31:0] rs1_a, rs2_a, pc_a, rs1_b, rs2_b, pc_b;
  logic        rdy_a, rdy_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  int          m_init_left;

  rv32i_regfile #(.RESET_PC(32'h0000_0000), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .reg_sel_rs1(reg_sel_rs1), .reg_sel_rs2(reg_sel_rs2),
    .reg_sel_rd(reg_sel_rd), .reg_rd(reg_rd), .rd_we(rd_we), .pc_in(pc_in),
    .pc_in_vld(pc_in_vld), .pc_step(pc_step), .reg_rs1(rs1_a), .reg_rs2(rs2_a),
    .pc_out(pc_a), .rf_ready(rdy_a));

  rv32i_regfile #(.RESET_PC(32'h0000_0000), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .reg_sel_rs1(reg_sel_rs1), .reg_sel_rs2(reg_sel_rs2),
    .reg_sel_rd(reg_sel_rd), .reg_rd(reg_rd), .rd_we(rd_we), .pc_in(pc_in),
    .pc_in_vld(pc_in_vld), .pc_step(pc_step), .reg_rs1(rs1_b), .reg_rs2(rs2_b),
    .pc_out(pc_b), .rf_ready(rdy_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural view of a read port: zero until ready, x0 is zero, else forwarded or stored.
  function automatic logic [31:0] m_read(input logic [31:0] sel, input bit fwd);
    int idx;
    idx = int'(sel[4:0]);
    if (m_init_left != 0 || idx == 0) return 32'h0;
    if (fwd && rd_we && int'(reg_sel_rd[4:0]) == idx) return reg_rd;
    return m_regs[idx];
  endfunction

  task automatic check_now();
    @(negedge clk);
    chk("rs1_fwd", rs1_a, m_read(reg_sel_rs1, 1'b1));
    chk("rs2_fwd", rs2_a, m_read(reg_sel_rs2, 1'b1));
    chk("rs1_nofwd", rs1_b, m_read(reg_sel_rs1, 1'b0));
    chk("rs2_nofwd", rs2_b, m_read(reg_sel_rs2, 1'b0));
    chk("pc", pc_a, m_pc);
    chk("pc_nofwd", pc_b, m_pc);
    chk("ready", {31'd0, rdy_a}, (m_init_left == 0) ? 32'd1 : 32'd0);
    chk("ready_nofwd", {31'd0, rdy_b}, (m_init_left == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic edge_update();
    @(posedge clk);
    if (rst) begin
      m_init_left = 31;
      m_pc = 32'h0000_0000;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else begin
      if (rd_we && reg_sel_rd[4:0] != 5'd0) m_regs[reg_sel_rd[4:0]] = reg_rd;
      if (pc_in_vld[0]) m_pc = pc_in & 32'hFFFF_FFFC;
      else if (pc_step) m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic run_cycle();
    check_now();
    edge_update();
  endtask

  task automatic idle();
    rst = 1'b0; rd_we = 1'b0; pc_step = 1'b0;
    pc_in = 32'h0; pc_in_vld = 32'h0;
    reg_sel_rs1 = 32'h0; reg_sel_rs2 = 32'h0; reg_sel_rd = 32'h0; reg_rd = 32'h0;
  endtask

  initial begin
    logic [31:0] r;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_init_left = 31;
    m_pc = 32'h0000_0000;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

    // Reset held, then the sweep with writes and PC controls that must be ignored.
    run_cycle();
    idle();
    rd_we = 1'b1; reg_sel_rd = 32'd5; reg_rd = 32'hCAFE_F00D;
    pc_step = 1'b1; pc_in = 32'h0000_0400; pc_in_vld = 32'h1;
    reg_sel_rs1 = 32'd5; reg_sel_rs2 = 32'd5;
    for (int i = 0; i < 31; i++) run_cycle();
    idle();
    check_now();
    chk("ready_after_sweep", {31'd0, rdy_a}, 32'd1);
    edge_update();
    for (int i = 1; i < 32; i++) begin
      reg_sel_rs1 = i; reg_sel_rs2 = 32 - i;
      run_cycle();
    end

    // Write then read, and a discarded write to x0.
    idle();
    rd_we = 1'b1; reg_sel_rd = 32'd7; reg_rd = 32'hDEAD_BEEF;
    run_cycle();
    idle();
    reg_sel_rs1 = 32'd7; reg_sel_rs2 = 32'd0;
    check_now();
    chk("x7_read", rs1_a, 32'hDEAD_BEEF);
    chk("x0_read", rs2_a, 32'h0);
    edge_update();
    rd_we = 1'b1; reg_sel_rd = 32'd0; reg_rd = 32'h0000_1234; reg_sel_rs1 = 32'd0;
    run_cycle();
    idle();
    run_cycle();

    // Same-cycle forwarding to both ports.
    rd_we = 1'b1; reg_sel_rd = 32'd3; reg_rd = 32'hA5A5_A5A5;
    reg_sel_rs1 = 32'd3; reg_sel_rs2 = 32'd3;
    check_now();
    chk("fwd_rs1", rs1_a, 32'hA5A5_A5A5);
    chk("fwd_rs2", rs2_a, 32'hA5A5_A5A5);
    chk("nofwd_rs1_old", rs1_b, 32'h0);
    edge_update();
    idle();

    // PC stepping, load-over-step with alignment, wrap at the top of the address space.
    pc_step = 1'b1;
    for (int i = 0; i < 3; i++) run_cycle();
    check_now();
    chk("pc_after_3_steps", pc_a, 32'd12);
    pc_in = 32'h0000_1003; pc_in_vld = 32'h1;
    edge_update();
    idle();
    check_now();
    chk("pc_load_wins", pc_a, 32'h0000_1000);
    pc_in = 32'hFFFF_FFFC; pc_in_vld = 32'h1;
    edge_update();
    idle();
    pc_step = 1'b1;
    run_cycle();
    idle();
    check_now();
    chk("pc_wrap", pc_a, 32'h0);
    edge_update();

    // Reset while running must rerun the full sweep and wipe earlier data.
    rd_we = 1'b1; reg_sel_rd = 32'd9; reg_rd = 32'h0000_0055; pc_step = 1'b1;
    run_cycle();
    idle();
    rst = 1'b1;
    run_cycle();
    idle();
    reg_sel_rs1 = 32'd9;
    check_now();
    chk("ready_low_after_rst", {31'd0, rdy_a}, 32'd0);
    chk("pc_after_rst", pc_a, 32'h0);
    edge_update();
    for (int i = 0; i < 30; i++) run_cycle();
    check_now();
    chk("x9_cleared", rs1_a, 32'h0);
    chk("ready_again", {31'd0, rdy_a}, 32'd1);
    edge_update();

    // Random traffic, including upper select bits, forwarding hits and rare resets.
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 249) == 0);
      reg_sel_rd = $urandom;
      if ($urandom_range(0, 2) == 0) reg_sel_rd[4:0] = 5'd0;
      reg_rd = $urandom;
      rd_we = ($urandom_range(0, 1) == 1);
      r = $urandom;
      reg_sel_rs1 = ($urandom_range(0, 2) == 0) ? {r[31:5], reg_sel_rd[4:0]} : r;
      r = $urandom;
      reg_sel_rs2 = ($urandom_range(0, 2) == 0) ? {r[31:5], reg_sel_rd[4:0]} : r;
      pc_in = $urandom;
      pc_in_vld = $urandom;
      pc_in_vld[0] = ($urandom_range(0, 3) == 0);
      pc_step = ($urandom_range(0, 1) == 1);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
